// File: rtl/posit_divsqrt_outbuf.sv
// Output decoupling FIFO for the posit div/sqrt unit: buffers {result, status, tag}
// behind a valid/ready handshake and accumulates sticky exception flags from delivered entries.
module posit_divsqrt_outbuf #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned STATUS_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [WIDTH-1:0]    result_i,
  input  logic [STATUS_W-1:0] status_i,
  input  logic                tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [WIDTH-1:0]    result_o,
  output logic [STATUS_W-1:0] status_o,
  output logic                tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [STATUS_W-1:0] fflags_o,
  input  logic                fflags_clr_i,
  output logic                busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]    res_q [DEPTH];
  logic [STATUS_W-1:0] st_q  [DEPTH];
  logic                tag_q [DEPTH];

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [STATUS_W-1:0] fflags;
  logic                push;
  logic                pop;

  // Ready is derived from registered occupancy only, so out_ready_i never
  // reaches the upstream unit combinationally.
  assign in_ready_o  = (count != CNT_W'(DEPTH));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i;

  assign result_o = res_q[rd_ptr];
  assign status_o = st_q[rd_ptr];
  assign tag_o    = tag_q[rd_ptr];
  assign fflags_o = fflags;
  assign busy_o   = out_valid_o | in_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q  <= '{default: '0};
      st_q   <= '{default: '0};
      tag_q  <= '{default: 1'b0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fflags <= '0;
    end else begin
      if (push) begin
        res_q[wr_ptr] <= result_i;
        st_q[wr_ptr]  <= status_i;
        tag_q[wr_ptr] <= tag_i;
      end
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      // A pop in a flush cycle is still a completed transfer, so it is always accumulated.
      fflags <= (fflags_clr_i ? '0 : fflags) | (pop ? status_o : '0);
    end
  end

endmodule

// File: tb/tb_posit_divsqrt_outbuf.sv
// Table-driven bench for posit_divsqrt_outbuf plus hand-written flush and async-reset sequences.
module tb_posit_divsqrt_outbuf;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] result_i = '0;
  logic [4:0]  status_i = '0;
  logic        tag_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        flush_i = 1'b0;
  logic [31:0] result_o;
  logic [4:0]  status_o;
  logic        tag_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i = 1'b0;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  posit_divsqrt_outbuf #(.WIDTH(32), .DEPTH(2), .STATUS_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .result_i(result_i), .status_i(status_i),
    .tag_i(tag_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .flush_i(flush_i),
    .result_o(result_o), .status_o(status_o), .tag_o(tag_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic [31:0] res;
    logic [4:0]  st;
    logic        tg;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic        ov;
    logic        ir;
    logic [31:0] ro;
    logic [4:0]  so;
    logic        to;
    logic [4:0]  ff;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [31:0] res, logic [4:0] st, logic tg,
                              logic ordy, logic clr, logic ov, logic ir,
                              logic [31:0] ro, logic [4:0] so, logic to,
                              logic [4:0] ff, logic busy);
    vec_t v;
    v.iv = iv; v.res = res; v.st = st; v.tg = tg; v.ordy = ordy; v.fl = 1'b0; v.clr = clr;
    v.ov = ov; v.ir = ir; v.ro = ro; v.so = so; v.to = to; v.ff = ff; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] res, input logic [4:0] st,
                       input logic tg, input logic ordy, input logic fl, input logic clr);
    in_valid_i = iv; result_i = res; status_i = st; tag_i = tg;
    out_ready_i = ordy; flush_i = fl; fflags_clr_i = clr;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Single transfer
    vecs.push_back(mk(1, 32'h4000_0000, 5'b01000, 1, 1, 0, 1, 1, 32'h4000_0000, 5'b01000, 1, 5'b00000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5'b01000, 0));
    // Backpressure / full
    vecs.push_back(mk(1, 32'h1, 5'b00000, 0, 0, 0, 1, 1, 32'h1, 5'b00000, 0, 5'b01000, 1));
    vecs.push_back(mk(1, 32'h2, 5'b00001, 1, 0, 0, 1, 0, 32'h1, 5'b00000, 0, 5'b01000, 1));
    vecs.push_back(mk(1, 32'h3, 5'b00100, 0, 0, 0, 1, 0, 32'h1, 5'b00000, 0, 5'b01000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 32'h2, 5'b00001, 1, 5'b01000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5'b01001, 0));
    // Streaming at count=1: one delivery per cycle, pointers wrap several times
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 32'h100 + 32'(i), 5'b00000, i[0], 1, 0, 1, 1,
                        32'h100 + 32'(i), 5'b00000, i[0], 5'b01001, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5'b01001, 0));
    // Sticky flags and clear/pop collision
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 5'b00000, 0));
    vecs.push_back(mk(1, 32'h11, 5'b00001, 0, 0, 0, 1, 1, 32'h11, 5'b00001, 0, 5'b00000, 1));
    vecs.push_back(mk(1, 32'h22, 5'b01000, 1, 1, 0, 1, 1, 32'h22, 5'b01000, 1, 5'b00001, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5'b01001, 0));
    vecs.push_back(mk(1, 32'h33, 5'b10000, 0, 0, 0, 1, 1, 32'h33, 5'b10000, 0, 5'b01001, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 5'b10000, 0));

    drive(0, 0, 0, 0, 0, 0, 0);
    #12 rst_ni = 1'b1;
    tick();
    chk("reset out_valid", 32'(out_valid_o), 32'd0);
    chk("reset in_ready", 32'(in_ready_o), 32'd1);
    chk("reset fflags", 32'(fflags_o), 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);

    foreach (vecs[k]) begin
      drive(vecs[k].iv, vecs[k].res, vecs[k].st, vecs[k].tg, vecs[k].ordy, vecs[k].fl, vecs[k].clr);
      tick();
      chk($sformatf("v%0d out_valid", k), 32'(out_valid_o), 32'(vecs[k].ov));
      chk($sformatf("v%0d in_ready", k), 32'(in_ready_o), 32'(vecs[k].ir));
      chk($sformatf("v%0d fflags", k), 32'(fflags_o), 32'(vecs[k].ff));
      chk($sformatf("v%0d busy", k), 32'(busy_o), 32'(vecs[k].busy));
      if (vecs[k].ov) begin
        chk($sformatf("v%0d result", k), result_o, vecs[k].ro);
        chk($sformatf("v%0d status", k), 32'(status_o), 32'(vecs[k].so));
        chk($sformatf("v%0d tag", k), 32'(tag_o), 32'(vecs[k].to));
      end
    end

    // Flush: two entries buffered, flush with a colliding push and pop
    drive(1, 32'hA1, 5'b00010, 1, 0, 0, 1);
    tick();
    drive(1, 32'hA2, 5'b00100, 0, 0, 0, 0);
    tick();
    chk("flush pre full", 32'(in_ready_o), 32'd0);
    chk("flush pre head", result_o, 32'hA1);
    drive(1, 32'hA3, 5'b00001, 1, 1, 1, 0);
    tick();
    chk("flush out_valid", 32'(out_valid_o), 32'd0);
    chk("flush in_ready", 32'(in_ready_o), 32'd1);
    chk("flush fflags", 32'(fflags_o), 32'h02);
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    chk("flush no ghost", 32'(out_valid_o), 32'd0);
    chk("flush fflags hold", 32'(fflags_o), 32'h02);
    drive(1, 32'hB0, 5'b00000, 1, 0, 0, 0);
    tick();
    chk("post-flush result", result_o, 32'hB0);
    chk("post-flush tag", 32'(tag_o), 32'd1);

    // Async reset mid-stream while full
    drive(1, 32'hB1, 5'b10000, 0, 0, 0, 0);
    tick();
    chk("pre-reset full", 32'(in_ready_o), 32'd0);
    #3 rst_ni = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid_o), 32'd0);
    chk("async fflags", 32'(fflags_o), 32'd0);
    chk("async in_ready", 32'(in_ready_o), 32'd1);
    chk("async result", result_o, 32'd0);
    chk("async busy", 32'(busy_o), 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0);
    #2 rst_ni = 1'b1;
    tick();
    chk("after reset empty", 32'(out_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
